// File: rtl/fpdiv_share_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fpdiv_share_ctrl_if
//  Purpose  : Requester-side and divider-side signal bundle for the shared
//             FP divider sequencer. The slave modport is the sequencer.
//             The master modport is its environment: the front ends and the
//             divider primitive.
//  Revision : 1.0 - initial release
// ============================================================================
interface fpdiv_share_ctrl_if #(
   parameter int NREQ  = 4,
   parameter int FPWID = 112
);
   // requester side
   logic [NREQ-1:0]       req;
   logic [NREQ*FPWID-1:0] a_i;
   logic [NREQ*FPWID-1:0] b_i;
   logic [NREQ-1:0]       ack_o;
   logic [NREQ-1:0]       done_o;
   logic [2*FPWID-1:0]    q_o;
   logic [FPWID-1:0]      r_o;
   logic [7:0]            lzcnt_o;
   logic                  dbz_o;
   logic                  busy_o;
   // divider side
   logic                  div_ld;
   logic [FPWID-1:0]      div_a;
   logic [FPWID-1:0]      div_b;
   logic [2*FPWID-1:0]    div_q;
   logic [FPWID-1:0]      div_r;
   logic [7:0]            div_lzcnt;
   logic                  div_done;

   modport slave (
      input  req, a_i, b_i, div_q, div_r, div_lzcnt, div_done,
      output ack_o, done_o, q_o, r_o, lzcnt_o, dbz_o, busy_o,
             div_ld, div_a, div_b
   );

   modport master (
      output req, a_i, b_i, div_q, div_r, div_lzcnt, div_done,
      input  ack_o, done_o, q_o, r_o, lzcnt_o, dbz_o, busy_o,
             div_ld, div_a, div_b
   );
endinterface
`default_nettype wire

// File: rtl/fpdiv_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fpdiv_share_ctrl
//  Purpose  : Round-robin sequencer that shares one radix-16 divider among
//             NREQ requesters. It latches the winner's operands and pulses
//             the divider load. It returns the tagged result on the divider's
//             done pulse. A zero divisor is answered locally in one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module fpdiv_share_ctrl #(
   parameter int NREQ  = 4,
   parameter int FPWID = 112,
   parameter int DRAIN = FPWID/2 + 4
) (
   input  logic              clk,
   input  logic              rst,
   fpdiv_share_ctrl_if.slave bus
);
   localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(DRAIN + 1);

   typedef enum logic [1:0] {
      S_DRAIN = 2'd0,
      S_IDLE  = 2'd1,
      S_BUSY  = 2'd2,
      S_ZRESP = 2'd3
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [TW-1:0]    ptr;
   logic [TW-1:0]    tag;

   logic             found;
   logic [TW-1:0]    pick;
   logic [FPWID-1:0] pick_a;
   logic [FPWID-1:0] pick_b;

   // Round-robin search: first requesting index after the last winner.
   always_comb begin
      int            k;
      logic [TW-1:0] kk;
      found = 1'b0;
      pick  = ptr;
      k     = 0;
      kk    = '0;
      for (int i = 1; i <= NREQ; i++) begin
         k = int'(ptr) + i;
         if (k >= NREQ) k = k - NREQ;
         kk = TW'(k);
         if (!found && bus.req[kk]) begin
            found = 1'b1;
            pick  = kk;
         end
      end
   end

   // Operand mux for the selected requester.
   always_comb begin
      pick_a = '0;
      pick_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick == TW'(k)) begin
            pick_a = bus.a_i[k*FPWID +: FPWID];
            pick_b = bus.b_i[k*FPWID +: FPWID];
         end
      end
   end

   // Sequencer: drain after reset, arbitrate, track the divider, return results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_DRAIN;
         cnt         <= CW'(DRAIN);
         ptr         <= TW'(NREQ - 1);
         tag         <= '0;
         bus.ack_o   <= '0;
         bus.done_o  <= '0;
         bus.q_o     <= '0;
         bus.r_o     <= '0;
         bus.lzcnt_o <= '0;
         bus.dbz_o   <= 1'b0;
         bus.busy_o  <= 1'b0;
         bus.div_ld  <= 1'b0;
         bus.div_a   <= '0;
         bus.div_b   <= '0;
      end else begin
         bus.ack_o  <= '0;
         bus.done_o <= '0;
         bus.div_ld <= 1'b0;
         case (state)
            // The divider cannot be reset, so any op it still holds must
            // finish unseen before a new load is allowed.
            S_DRAIN: begin
               if (cnt <= CW'(1)) begin
                  cnt        <= '0;
                  state      <= S_IDLE;
                  bus.busy_o <= 1'b0;
               end else begin
                  cnt        <= cnt - CW'(1);
                  bus.busy_o <= 1'b1;
               end
            end
            S_IDLE: begin
               if (found) begin
                  bus.ack_o  <= NREQ'(1) << pick;
                  tag        <= pick;
                  ptr        <= pick;
                  bus.div_a  <= pick_a;
                  bus.div_b  <= pick_b;
                  bus.busy_o <= 1'b1;
                  if (pick_b == '0) begin
                     state <= S_ZRESP;
                  end else begin
                     bus.div_ld <= 1'b1;
                     state      <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (bus.div_done) begin
                  bus.q_o     <= bus.div_q;
                  bus.r_o     <= bus.div_r;
                  bus.lzcnt_o <= bus.div_lzcnt;
                  bus.dbz_o   <= 1'b0;
                  bus.done_o  <= NREQ'(1) << tag;
                  bus.busy_o  <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            S_ZRESP: begin
               bus.q_o     <= '1;
               bus.r_o     <= '0;
               bus.lzcnt_o <= '0;
               bus.dbz_o   <= 1'b1;
               bus.done_o  <= NREQ'(1) << tag;
               bus.busy_o  <= 1'b0;
               state       <= S_IDLE;
            end
            default: begin
               state <= S_DRAIN;
               cnt   <= CW'(DRAIN);
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_fpdiv_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpdiv_share_ctrl
//  Purpose  : Self-checking bench for fpdiv_share_ctrl with a behavioural
//             divider and a round-robin reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpdiv_share_ctrl;
   localparam int NREQ  = 4;
   localparam int FPWID = 112;
   localparam int QW    = 2 * FPWID;
   localparam int DRAIN = FPWID/2 + 4;
   localparam int LATENCY = FPWID/2 + 4;   // ack_o to done_o
   localparam int DIVLAT  = LATENCY - 1;   // load seen to div_done

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic done_allowed = 1'b0;
   logic inj   = 1'b0;
   logic mdone = 1'b0;
   int   last  = NREQ - 1;

   logic [FPWID-1:0] opa [NREQ];
   logic [FPWID-1:0] opb [NREQ];

   fpdiv_share_ctrl_if #(.NREQ(NREQ), .FPWID(FPWID)) bus ();

   fpdiv_share_ctrl #(.NREQ(NREQ), .FPWID(FPWID), .DRAIN(DRAIN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.div_done = mdone | inj;

   // ---------------- helpers ----------------
   function automatic void chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic void chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected event", name);
   endfunction

   // Reference divide: quotient of a*2^FPWID by b, remainder, leading zeros.
   function automatic void ref_div(input logic [FPWID-1:0] a, input logic [FPWID-1:0] b,
                                   output logic [QW-1:0] q, output logic [FPWID-1:0] r,
                                   output logic [7:0] lz, output logic dbz);
      logic [QW-1:0] n;
      logic [QW-1:0] d;
      logic [QW-1:0] rem;
      int  cnt;
      bit  seen;
      if (b == '0) begin
         q = '1; r = '0; lz = '0; dbz = 1'b1;
      end else begin
         n   = {a, {FPWID{1'b0}}};
         d   = {{FPWID{1'b0}}, b};
         q   = n / d;
         rem = n % d;
         r   = rem[FPWID-1:0];
         cnt = 0; seen = 0;
         for (int i = QW-1; i >= 0; i--) begin
            if (q[i]) seen = 1;
            if (!seen) cnt++;
         end
         lz  = 8'(cnt);
         dbz = 1'b0;
      end
   endfunction

   function automatic logic [FPWID-1:0] rand_op();
      logic [FPWID-1:0] v;
      for (int i = 0; i < FPWID/4; i++) v[i*4 +: 4] = 4'($urandom);
      return v >> $urandom_range(0, FPWID-1);
   endfunction

   function automatic int next_winner(input logic [NREQ-1:0] mask, input int from);
      for (int i = 1; i <= NREQ; i++)
         if (mask[(from + i) % NREQ]) return (from + i) % NREQ;
      return -1;
   endfunction

   task automatic drive_ops();
      for (int k = 0; k < NREQ; k++) begin
         bus.a_i[k*FPWID +: FPWID] = opa[k];
         bus.b_i[k*FPWID +: FPWID] = opb[k];
      end
   endtask

   task automatic check_zero(input string tagname);
      chk_vec({tagname, "_ack"},   256'(bus.ack_o),   256'(0));
      chk_vec({tagname, "_done"},  256'(bus.done_o),  256'(0));
      chk_vec({tagname, "_q"},     256'(bus.q_o),     256'(0));
      chk_vec({tagname, "_r"},     256'(bus.r_o),     256'(0));
      chk_vec({tagname, "_lz"},    256'(bus.lzcnt_o), 256'(0));
      chk_int({tagname, "_dbz"},   int'(bus.dbz_o),   0);
      chk_int({tagname, "_busy"},  int'(bus.busy_o),  0);
      chk_int({tagname, "_divld"}, int'(bus.div_ld),  0);
      chk_vec({tagname, "_diva"},  256'(bus.div_a),   256'(0));
      chk_vec({tagname, "_divb"},  256'(bus.div_b),   256'(0));
   endtask

   task automatic wait_ack(input int limit, output int who, output int cyc);
      who = -1; cyc = 0;
      while (who < 0 && cyc < limit) begin
         @(negedge clk);
         cyc++;
         for (int k = 0; k < NREQ; k++) if (bus.ack_o[k] && who < 0) who = k;
      end
      if (who < 0) fail("ack_timeout");
   endtask

   task automatic after_ack(input int who, input int exp_who);
      chk_int("grant_who", who, exp_who);
      chk_vec("ack_vec", 256'(bus.ack_o), 256'(NREQ'(1) << exp_who));
      chk_int("div_ld_at_ack", int'(bus.div_ld), int'(opb[exp_who] != '0));
      chk_vec("div_a", 256'(bus.div_a), 256'(opa[exp_who]));
      chk_vec("div_b", 256'(bus.div_b), 256'(opb[exp_who]));
      chk_int("busy_at_ack", int'(bus.busy_o), 1);
      last = exp_who;
   endtask

   task automatic wait_done(input int who, input logic [FPWID-1:0] a, input logic [FPWID-1:0] b,
                            input int exp_lat, input int exp_dbz);
      logic [QW-1:0]    q;
      logic [FPWID-1:0] r;
      logic [7:0]       lz;
      logic             d;
      int cyc;
      bit got;
      ref_div(a, b, q, r, lz, d);
      done_allowed = 1'b1;
      cyc = 0; got = 0;
      while (!got && cyc < exp_lat + 20) begin
         @(negedge clk);
         cyc++;
         if (bus.done_o != '0) got = 1;
      end
      if (!got) fail("done_timeout");
      else begin
         chk_vec("done_vec", 256'(bus.done_o), 256'(NREQ'(1) << who));
         chk_int("latency", cyc, exp_lat);
         chk_vec("q", 256'(bus.q_o), 256'(q));
         chk_vec("r", 256'(bus.r_o), 256'(r));
         chk_vec("lz", 256'(bus.lzcnt_o), 256'(lz));
         chk_int("dbz", int'(bus.dbz_o), exp_dbz);
         chk_int("div_ld_at_done", int'(bus.div_ld), 0);
      end
      done_allowed = 1'b0;
   endtask

   // ---------------- behavioural divider (no reset) ----------------
   int               dcnt = 0;
   logic [FPWID-1:0] da = '0;
   logic [FPWID-1:0] db = '0;
   logic [QW-1:0]    dq;
   logic [FPWID-1:0] dr;
   logic [7:0]       dlz;
   logic             ddbz;
   always @(negedge clk) begin
      mdone = 1'b0;
      if (dcnt > 0) begin
         dcnt--;
         if (dcnt == 0) begin
            ref_div(da, db, dq, dr, dlz, ddbz);
            bus.div_q     = dq;
            bus.div_r     = dr;
            bus.div_lzcnt = dlz;
            mdone         = 1'b1;
         end
      end
      if (bus.div_ld) begin
         da   = bus.div_a;
         db   = bus.div_b;
         dcnt = DIVLAT;
      end
   end

   // ---------------- always-on protocol checks ----------------
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         chk_int("ack_onehot0", int'($countones(bus.ack_o) <= 1), 1);
         chk_int("done_onehot0", int'($countones(bus.done_o) <= 1), 1);
         chk_int("ack_done_excl", int'((bus.ack_o != '0) && (bus.done_o != '0)), 0);
         if (!done_allowed) chk_vec("unexpected_done", 256'(bus.done_o), 256'(0));
      end
   end

   // ---------------- table ----------------
   typedef struct {
      int               who;
      logic [FPWID-1:0] a;
      logic [FPWID-1:0] b;
      int               lat;
      int               dbz;
      logic [QW-1:0]    q;
      logic [FPWID-1:0] r;
      logic [7:0]       lz;
   } vec_t;
   vec_t tv [5];

   // ---------------- main sequence ----------------
   initial begin
      int who, cyc, exp;
      logic [FPWID-1:0] a, b;
      logic [NREQ-1:0] mask;
      logic [QW-1:0] sq;
      logic [FPWID-1:0] sr;
      logic [7:0] slz;

      tv[0] = '{1, 112'h1 << 108, 112'h1 << 108, LATENCY, 0, 224'h1 << 112, '0, 8'd111};
      tv[1] = '{2, 112'hDEAD_BEEF, '0, 1, 1, {QW{1'b1}}, '0, 8'd0};
      tv[2] = '{0, 112'h6, 112'h3, LATENCY, 0, 224'h2 << 112, '0, 8'd110};
      tv[3] = '{3, {FPWID{1'b1}}, 112'h1, LATENCY, 0, {{FPWID{1'b1}}, {FPWID{1'b0}}}, '0, 8'd0};
      tv[4] = '{1, 112'h5, {FPWID{1'b1}}, LATENCY, 0, 224'h5, 112'h5, 8'd221};

      bus.req = '0;
      bus.div_q = '0; bus.div_r = '0; bus.div_lzcnt = '0;
      for (int k = 0; k < NREQ; k++) begin opa[k] = rand_op(); opb[k] = rand_op() | 1; end
      drive_ops();
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset");

      // Reset release with requester 0 already waiting.
      opa[0] = rand_op(); opb[0] = rand_op() | 1; drive_ops();
      bus.req = 4'b0001;
      rst = 1'b0;
      last = NREQ - 1;
      wait_ack(200, who, cyc);
      chk_int("drain_len", cyc, DRAIN + 1);
      after_ack(who, 0);
      bus.req = '0;
      wait_done(0, opa[0], opb[0], LATENCY, 0);

      // Table-driven single ops.
      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k < NREQ; k++) begin opa[k] = rand_op(); opb[k] = rand_op(); end
         opa[tv[v].who] = tv[v].a;
         opb[tv[v].who] = tv[v].b;
         drive_ops();
         bus.req = NREQ'(1) << tv[v].who;
         wait_ack(10, who, cyc);
         after_ack(who, tv[v].who);
         bus.req = '0;
         wait_done(tv[v].who, tv[v].a, tv[v].b, tv[v].lat, tv[v].dbz);
         chk_vec("tbl_q", 256'(bus.q_o), 256'(tv[v].q));
         chk_vec("tbl_r", 256'(bus.r_o), 256'(tv[v].r));
         chk_vec("tbl_lz", 256'(bus.lzcnt_o), 256'(tv[v].lz));
      end

      // Spurious div_done while idle leaves results untouched.
      sq = bus.q_o; sr = bus.r_o; slz = bus.lzcnt_o;
      @(negedge clk); inj = 1'b1;
      @(negedge clk); inj = 1'b0;
      repeat (3) @(negedge clk);
      chk_vec("spur_q", 256'(bus.q_o), 256'(sq));
      chk_vec("spur_r", 256'(bus.r_o), 256'(sr));
      chk_vec("spur_lz", 256'(bus.lzcnt_o), 256'(slz));
      chk_int("spur_busy", int'(bus.busy_o), 0);

      // Fresh reset, all requesters held high: 0,1,2,3,0 back to back.
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) begin opa[k] = rand_op(); opb[k] = rand_op() | 1; end
      drive_ops();
      bus.req = 4'b1111;
      rst = 1'b0;
      last = NREQ - 1;
      for (int g = 0; g < 5; g++) begin
         wait_ack((g == 0) ? 200 : 10, who, cyc);
         if (g == 0) chk_int("drain_len_rr", cyc, DRAIN + 1);
         else        chk_int("b2b_gap", cyc, 1);
         exp = next_winner(bus.req, last);
         chk_int("rr_order", who, g % NREQ);
         a = opa[exp]; b = opb[exp];
         after_ack(who, exp);
         opa[exp] = rand_op(); opb[exp] = rand_op(); drive_ops();
         wait_done(exp, a, b, (b == '0) ? 1 : LATENCY, int'(b == '0));
      end
      bus.req = '0;
      @(negedge clk);

      // Randomised masks and operands against the round-robin reference.
      for (int it = 0; it < 10; it++) begin
         for (int k = 0; k < NREQ; k++) begin
            opa[k] = rand_op();
            opb[k] = ($urandom_range(0, 3) == 0) ? '0 : (rand_op() | 1);
         end
         drive_ops();
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         bus.req = mask;
         exp = next_winner(mask, last);
         wait_ack(10, who, cyc);
         a = opa[exp]; b = opb[exp];
         after_ack(who, exp);
         bus.req = '0;
         wait_done(exp, a, b, (b == '0) ? 1 : LATENCY, int'(b == '0));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset 20 cycles into BUSY: result dropped, stale div_done ignored.
      opa[1] = rand_op(); opb[1] = rand_op() | 1; drive_ops();
      bus.req = 4'b0010;
      wait_ack(10, who, cyc);
      after_ack(who, next_winner(4'b0010, last));
      bus.req = '0;
      repeat (20) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_zero("midrst");
      @(negedge clk);
      opa[3] = rand_op(); opb[3] = rand_op() | 1; drive_ops();
      bus.req = 4'b1000;
      rst = 1'b0;
      last = NREQ - 1;
      wait_ack(200, who, cyc);
      chk_int("drain_len_midrst", cyc, DRAIN + 1);
      after_ack(who, 3);
      bus.req = '0;
      wait_done(3, opa[3], opb[3], LATENCY, 0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog in case the sequence stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire

// File: doc/fpdiv_share_ctrl.md
Name: fpdiv_share_ctrl

Overview:
Sequencer and round-robin arbiter that shares one radix-16 divider primitive among NREQ requesters. It latches each winner's operands and pulses the divider load. It waits for the divider's done pulse, then returns quotient, remainder and leading-zero count tagged to the winner. Divide-by-zero is handled locally without occupying the divider. It sits between the FP divide front ends (per-lane normalisers) and the single shared divider instance.

Parameters:
NREQ, 4, number of requesters (2..8)
FPWID, 112, divider operand width; multiple of 4
DRAIN, FPWID/2+4, post-reset cycles during which the divider is treated as possibly busy

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req  in  NREQ  per-requester level request
a_i  in  NREQ*FPWID  dividend, slice k belongs to requester k
b_i  in  NREQ*FPWID  divisor, slice k belongs to requester k
ack_o  out  NREQ  one-hot, 1-cycle pulse: operands captured
done_o  out  NREQ  one-hot, 1-cycle pulse: result valid
q_o  out  2*FPWID  quotient, valid with done_o
r_o  out  FPWID  remainder, valid with done_o
lzcnt_o  out  8  quotient leading-zero count, valid with done_o
dbz_o  out  1  divide-by-zero flag, valid with done_o
busy_o  out  1  high in any state other than IDLE
div_ld  out  1  load pulse to divider
div_a  out  FPWID  latched dividend
div_b  out  FPWID  latched divisor
div_q  in  2*FPWID  divider quotient
div_r  in  FPWID  divider remainder
div_lzcnt  in  8  divider lzcnt
div_done  in  1  divider completion pulse

Behaviour:
- All outputs are registered. Reset value of every output is 0. Round-robin pointer resets to NREQ-1, so requester 0 wins first. State resets to DRAIN with the counter at DRAIN.
- Reset is honoured mid-operation: everything clears and any in-flight result is dropped. The divider has no reset and may still complete, so DRAIN blocks grants for DRAIN cycles and ignores div_done. DRAIN then goes to IDLE.
- IDLE: if any req is high, grant the first requester at or after pointer+1, modulo NREQ. At that edge:
  - ack_o[k]=1, latch a/b slice k and tag k, pointer=k.
  - If latched b==0, go to ZRESP.
  - Otherwise set div_ld=1 and go to BUSY.
  - No req: remain idle. div_done in IDLE is ignored.
- BUSY: div_ld drops after one cycle; div_a and div_b stay stable. On div_done:
  - Capture div_q, div_r, div_lzcnt into q_o/r_o/lzcnt_o with dbz_o=0.
  - done_o[tag]=1 for one cycle, then go to IDLE.
- ZRESP: one cycle. q_o = all ones, r_o = 0, lzcnt_o = 0, dbz_o = 1, done_o[tag]=1, then go to IDLE.
- Result outputs hold their values until the next done_o.
- Latency, FPWID=112:
  - ack_o to done_o = FPWID/2+4 = 60 cycles.
  - Zero divisor: 1 cycle.
  - Next grant is possible on the edge after done_o, so back-to-back issue costs FPWID/2+5 cycles per op.
- req is a level signal. A requester still high on the cycle after its ack_o is a new request and re-arbitrates normally. Operands need only be valid in the cycle the grant is taken.
- req changes while BUSY have no effect until IDLE.
- Never more than one ack_o bit or done_o bit is set. ack_o and done_o are never high in the same cycle.

Test Plan:
- Reset release: req[0]=1 immediately → no ack_o for DRAIN=60 cycles, then ack_o=4'b0001.
- Single op, req[1], a=0x1<<108, b=0x1<<108 → done_o=4'b0010 exactly 60 cycles after ack_o. q_o equals the divider model for the same operands; r_o=0; dbz_o=0.
- All four req held high → grants follow 0,1,2,3,0 with each done_o matching its own ack tag. No requester is granted twice before the others get a turn.
- req[2] with b=0 → ack_o=4'b0100, next cycle done_o=4'b0100, q_o all ones, r_o=0, dbz_o=1, div_ld never asserted.
- rst pulsed 20 cycles into BUSY → all outputs 0 immediately, no done_o for that op, and no grant for 60 cycles. The stale div_done arriving during DRAIN produces no done_o.
- Spurious div_done injected in IDLE → no done_o, and q_o/r_o are unchanged.
